sound_event_queue: RTL and testbench

- Sits between the COSMIC core's sound-port outputs and the samples player.
- Samples the 16-bit trigger and 16-bit stop ports on each CPU enable and detects rising edges.
- Serialises the edges into a FIFO of discrete start/stop events, which it delivers to the sample player over a valid/ready handshake.
- Simultaneous port writes therefore cannot be lost, and overflow is visible to software and debug.

---
 rtl/sound_event_queue.sv | 141 ++++++++++++++
 tb/tb_sound_event_queue.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sound_event_queue.sv
// Turns rising edges on the sound trigger/stop ports into a FIFO of start/stop events.
// Optional macro SOUND_EVT_DROP_COUNT_EN builds the saturating coalesced-edge counter.
module sound_event_queue #(
    parameter int unsigned CHANNELS = 16,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic                      cpu_ena,
    input  logic [CHANNELS-1:0]       trig_in,
    input  logic [CHANNELS-1:0]       stop_in,
    input  logic                      pause,
    input  logic                      evt_ready,
    output logic                      evt_valid,
    output logic [3:0]                evt_chan,
    output logic                      evt_start,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    input  logic                      clear_ovf,
    output logic [15:0]               drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic                first;
    logic [CHANNELS-1:0] prev_trig, prev_stop;
    logic [CHANNELS-1:0] pend_start, pend_stop;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [3:0]          mem_chan [DEPTH];
    logic                mem_start [DEPTH];

    logic [CHANNELS-1:0] rise_t, rise_s;
    logic [CHANNELS-1:0] onehot, clr_start, clr_stop;
    logic [CHANNELS-1:0] coal_t, coal_s;
    logic [3:0]          sel;
    logic                hit, sel_stop;
    logic                full, push, pop, new_ovf;

    // Edge detect; the first enabled sample after reset only primes prev.
    always_comb begin
        rise_t = '0;
        rise_s = '0;
        if (cpu_ena && !first) begin
            rise_t = trig_in & ~prev_trig;
            rise_s = stop_in & ~prev_stop;
        end
    end

    // Lowest-index pending channel wins; stop takes precedence over start.
    always_comb begin
        hit      = 1'b0;
        sel      = '0;
        sel_stop = 1'b0;
        onehot   = '0;
        for (int i = int'(CHANNELS) - 1; i >= 0; i--) begin
            if (pend_stop[i] || pend_start[i]) begin
                hit       = 1'b1;
                sel       = 4'(i);
                sel_stop  = pend_stop[i];
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign evt_valid = (level != '0) && !pause;
    assign evt_chan  = mem_chan[rd_ptr];
    assign evt_start = mem_start[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    assign full      = (level == LW'(DEPTH));
    assign push      = hit && (!full || pop);
    assign clr_stop  = (push && sel_stop)  ? onehot : '0;
    assign clr_start = (push && !sel_stop) ? onehot : '0;
    assign coal_t    = rise_t & pend_start & ~clr_start;
    assign coal_s    = rise_s & pend_stop & ~clr_stop;
    assign new_ovf   = |{coal_t, coal_s};

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            first      <= 1'b1;
            prev_trig  <= '0;
            prev_stop  <= '0;
            pend_start <= '0;
            pend_stop  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_chan[i]  <= '0;
                mem_start[i] <= 1'b0;
            end
        end else begin
            if (cpu_ena) begin
                first     <= 1'b0;
                prev_trig <= trig_in;
                prev_stop <= stop_in;
            end
            // A rise in the same cycle as the scanner clears the bit keeps it set.
            pend_start <= (pend_start & ~clr_start) | rise_t;
            pend_stop  <= (pend_stop & ~clr_stop) | rise_s;
            if (push) begin
                mem_chan[wr_ptr]  <= sel;
                mem_start[wr_ptr] <= !sel_stop;
                wr_ptr            <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            overflow <= new_ovf || (overflow && !clear_ovf);
        end
    end

`ifdef SOUND_EVT_DROP_COUNT_EN
    logic [5:0]  n_coal;
    logic [15:0] drop_q;
    logic [16:0] drop_sum;

    always_comb begin
        n_coal = '0;
        for (int i = 0; i < int'(CHANNELS); i++)
            n_coal = n_coal + 6'(coal_t[i]) + 6'(coal_s[i]);
        drop_sum = (clear_ovf ? 17'd0 : {1'b0, drop_q}) + 17'(n_coal);
    end

    // Saturates at 0xFFFF.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) drop_q <= '0;
        else          drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_sound_event_queue.sv
// Directed bench for sound_event_queue: expected events queued at stimulus time, checked by a monitor.
module tb_sound_event_queue;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        cpu_ena;
    logic [15:0] trig_in, stop_in;
    logic        pause, evt_ready, clear_ovf;
    logic        evt_valid, evt_start, overflow;
    logic [3:0]  evt_chan;
    logic [3:0]  level;
    logic [15:0] drop_count;

    int vectors = 0;
    int errors  = 0;
    int xfers   = 0;
    logic [4:0] exp_q [$];

    sound_event_queue dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cpu_ena   (cpu_ena),
        .trig_in   (trig_in),
        .stop_in   (stop_in),
        .pause     (pause),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_chan  (evt_chan),
        .evt_start (evt_start),
        .level     (level),
        .overflow  (overflow),
        .clear_ovf (clear_ovf),
        .drop_count(drop_count)
    );

    always #5 clk_sys = ~clk_sys;

    // Monitor: every committed transfer must match the head of the expected queue.
    always @(negedge clk_sys) begin
        if (reset_n && evt_valid && evt_ready) begin
            vectors++;
            xfers++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event got chan=%0d start=%0d, expected none", evt_chan, evt_start);
            end else begin
                logic [4:0] e;
                e = exp_q.pop_front();
                if ({evt_chan, evt_start} !== e) begin
                    errors++;
                    $display("FAIL event got chan=%0d start=%0d, expected chan=%0d start=%0d",
                             evt_chan, evt_start, e[4:1], e[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic sample(input logic [15:0] t, input logic [15:0] s);
        trig_in = t;
        stop_in = s;
        cpu_ena = 1'b1;
        tick();
        cpu_ena = 1'b0;
    endtask

    task automatic expect_evt(input int chan, input logic start);
        exp_q.push_back({4'(chan), start});
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] acc;
        int exp_drop;
`ifdef SOUND_EVT_DROP_COUNT_EN
        exp_drop = 1;
`else
        exp_drop = 0;
`endif
        reset_n = 1'b0; cpu_ena = 1'b0; trig_in = 16'h0001; stop_in = '0;
        pause = 1'b0; evt_ready = 1'b0; clear_ovf = 1'b0;
        ticks(2);
        check("rst_valid", evt_valid, 0);
        check("rst_level", level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_count, 0);
        check("rst_chan", evt_chan, 0);
        reset_n = 1'b1;
        tick();

        // Bit high out of reset never fires.
        sample(16'h0001, 16'h0);
        sample(16'h0001, 16'h0);
        ticks(3);
        check("hi_at_reset_level", level, 0);
        check("hi_at_reset_valid", evt_valid, 0);

        // 0x0 -> 0x5: chan0 at T+2, chan2 next cycle.
        sample(16'h0, 16'h0);
        ticks(2);
        evt_ready = 1'b1;
        expect_evt(0, 1'b1);
        expect_evt(2, 1'b1);
        sample(16'h0005, 16'h0);
        check("lat_t1_valid", evt_valid, 0);
        tick();
        check("lat_t2_valid", evt_valid, 1);
        check("lat_t2_chan", evt_chan, 0);
        tick();
        check("lat_t3_chan", evt_chan, 2);
        check("lat_t3_valid", evt_valid, 1);
        tick();
        check("lat_drain_level", level, 0);

        // Stop before start on the same channel.
        sample(16'h0, 16'h0);
        expect_evt(3, 1'b0);
        expect_evt(3, 1'b1);
        sample(16'h0008, 16'h0008);
        ticks(5);
        check("stop_first_level", level, 0);
        sample(16'h0, 16'h0);

        // Ten rises into an 8-deep FIFO with no consumer.
        evt_ready = 1'b0;
        acc = '0;
        for (int i = 0; i < 10; i++) begin
            acc[i] = 1'b1;
            sample(acc, 16'h0);
            expect_evt(i, 1'b1);
        end
        ticks(4);
        check("full_level", level, 8);
        check("full_no_ovf", overflow, 0);
        base = xfers;
        evt_ready = 1'b1;
        ticks(14);
        check("full_drain_count", xfers - base, 10);
        check("full_drain_level", level, 0);
        sample(16'h0, 16'h0);

        // Coalesce on bit 4 while stalled behind a full FIFO.
        evt_ready = 1'b0;
        sample(16'hFF00, 16'h0);
        for (int i = 8; i < 16; i++) expect_evt(i, 1'b1);
        ticks(10);
        check("ovf_full_level", level, 8);
        sample(16'hFF10, 16'h0);
        sample(16'hFF00, 16'h0);
        check("ovf_before", overflow, 0);
        sample(16'hFF10, 16'h0);
        check("ovf_set", overflow, 1);
        check("ovf_drop", drop_count, exp_drop);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        check("drop_cleared", drop_count, 0);
        expect_evt(4, 1'b1);
        evt_ready = 1'b1;
        ticks(12);
        check("ovf_drain_level", level, 0);
        sample(16'h0, 16'h0);

        // Paused burst then release.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) expect_evt(i, 1'b1);
        sample(16'h0007, 16'h0);
        ticks(5);
        check("pause_valid", evt_valid, 0);
        check("pause_level", level, 3);
        check("pause_chan", evt_chan, 0);
        pause = 1'b0;
        tick();
        check("resume_level1", level, 2);
        tick();
        check("resume_level2", level, 1);
        tick();
        check("resume_level3", level, 0);

        ticks(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
